button_event: RTL and testbench
===============================

# button_event

Classifies button gestures from a clean, debounced level. The block sits directly downstream of the button debouncer and consumes its debounced output. It emits one-cycle event pulses for press, release, single click, double click and long press, plus a held level. The rest of the design consumes these pulses instead of edge-detecting raw levels.

## Interface
Parameters:
- c_clkfreq, 'd100000000, clock frequency in Hz; one ms tick = c_clkfreq/1000 clocks
- c_longms, 'd1000, hold time in ms that qualifies a long press
- c_dblms, 'd300, max gap in ms between first release and second press for a double click

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- signal_i  input  1  debounced button level, 1 = pressed, synchronous to clk
- press_o  output  1  one-cycle pulse on every 0->1 of signal_i
- release_o  output  1  one-cycle pulse on every 1->0 of signal_i
- short_o  output  1  one-cycle pulse: single click confirmed
- double_o  output  1  one-cycle pulse: double click confirmed
- long_o  output  1  one-cycle pulse when hold reaches c_longms
- held_o  output  1  level, high from long_o until release

## Operation
- Edge detect: signal_q <= signal_i; rise = signal_i & ~signal_q; fall = ~signal_i & signal_q.
- All outputs are registered. Reset value of every output is 0. State resets to S_IDLE, signal_q resets to 0, and timers reset to 0.
- A button already held at reset release produces press_o on the first clock.
- Timer: ms prescaler of width $clog2(c_clkfreq/1000) produces tick. A 16-bit ms counter increments on tick. Both clear on every state entry.
- States:
  - S_IDLE: on rise -> S_PRESS1.
  - S_PRESS1: on fall -> S_GAP. When ms counter = c_longms -> S_LONG, long_o, held_o <= 1.
  - S_LONG: on fall -> S_IDLE, held_o <= 0.
  - S_GAP: on rise -> S_PRESS2. When ms counter = c_dblms -> S_IDLE, short_o.
  - S_PRESS2: on fall -> S_IDLE, double_o. When ms counter = c_longms -> S_LONG, long_o, held_o <= 1, no double_o.
- press_o and release_o fire on every edge in every state, independent of classification.
- Exactly one of short_o, double_o or long_o fires per gesture. A long hold on the second press yields long_o only; the first click is discarded.
- Simultaneous edge and timer expiry in the same cycle: the edge wins.
  - In S_PRESS1, fall at the long expiry goes to S_GAP with no long_o.
  - In S_GAP, rise at the dbl expiry goes to S_PRESS2 with no short_o.
- Reset asserted mid-gesture aborts it immediately (async). No pending pulse is emitted after reset.

## Timing
- press_o/release_o: high for the cycle after the first clock edge that samples the new level. Latency is 1 clock from the input change.
- long_o: fires c_longms*(c_clkfreq/1000) clocks ±1 after press_o.
- short_o: fires c_dblms*(c_clkfreq/1000) clocks ±1 after the release_o of the first click.
- double_o: in the same cycle as the second release_o.
- held_o: rises with long_o and falls with release_o.
- No back-pressure. Pulses are never stretched or queued.

## Structure
- Shared package button_pkg holds:
  - state encodings S_IDLE..S_PRESS2 (3 bits)
  - the ms-divider constant c_clkfreq/1000
  - the ms counter width (16)
- Sub-module ms_timer contains the prescaler, tick and ms counter.
  - Ports: clk, rst, clr_i, ms_o[15:0].
  - Instantiated once; clr_i pulses on state entry.
- The FSM and edge detect live in button_event.

## Test plan
Bench parameters: c_clkfreq=10000 (10 clk/ms), c_longms=5, c_dblms=3.
- High for 20 clk, then low -> press_o at clk 1, release_o at clk 21, short_o about 30 clk after release_o. No double_o or long_o.
- High 20, low 10, high 20, low -> two press_o and two release_o. double_o in the cycle of the second release_o. No short_o.
- High for 80 clk -> long_o and held_o rise about 50 clk after press_o. held_o falls with release_o. No short_o or double_o.
- Force fall on the exact cycle the ms counter reaches 5 in S_PRESS1 -> no long_o; short_o follows after the gap expires.
- Click, then second press held 60 clk -> long_o only. No double_o or short_o.
- Assert rst for 3 clk during S_GAP -> all outputs 0 immediately. No short_o afterwards. signal_i=1 at reset release gives press_o on the next clock.

Source files
------------

// File: rtl/button_pkg.sv
// button_pkg: shared state encoding and timer constants for button_event
package button_pkg;
  localparam int c_ms_w = 16;
  typedef enum logic [2:0] {S_IDLE, S_PRESS1, S_LONG, S_GAP, S_PRESS2} state_t;
  function automatic int ms_div(input int clkfreq);
    return clkfreq / 1000;
  endfunction
endpackage

// File: rtl/button_event_if.sv
// button_event_if: debounced button level in, gesture pulses out
interface button_event_if;
  logic btn, press, rel, short_click, double_click, long_press, held;
  modport master(output btn, input press, rel, short_click, double_click, long_press, held);
  modport slave(input btn, output press, rel, short_click, double_click, long_press, held);
endinterface

// File: rtl/ms_timer.sv
// ms_timer: clock prescaler producing a millisecond counter, cleared on demand
module ms_timer import button_pkg::*; #(
  parameter int c_div = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  output logic [c_ms_w-1:0] ms_o
);
  localparam int c_pw = c_div > 1 ? $clog2(c_div) : 1;
  logic [c_pw-1:0] pre;
  logic tick;
  assign tick = pre == c_pw'(c_div - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre  <= '0;
      ms_o <= '0;
    end else if (clr_i) begin
      pre  <= '0;
      ms_o <= '0;
    end else begin
      pre  <= tick ? '0 : pre + 1'b1;
      ms_o <= ms_o + c_ms_w'(tick);
    end
endmodule

// File: rtl/button_event.sv
// button_event: classifies press/release/click/double/long gestures from a debounced level
module button_event import button_pkg::*; #(
  parameter int c_clkfreq = 100000000,
  parameter int c_longms  = 1000,
  parameter int c_dblms   = 300
) (
  input logic clk,
  input logic rst,
  button_event_if.slave bus
);
  state_t state, state_n;
  logic sig_q, rise, fall, at_long, at_dbl;
  logic shrt_n, dbl_n, lng_n, held_n;
  logic [c_ms_w-1:0] ms;
  assign rise    = bus.btn & ~sig_q;
  assign fall    = ~bus.btn & sig_q;
  assign at_long = ms == c_ms_w'(c_longms);
  assign at_dbl  = ms == c_ms_w'(c_dblms);
  // timer restarts whenever the FSM moves, so each state measures its own dwell
  ms_timer #(.c_div(ms_div(c_clkfreq))) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr_i(state_n != state),
    .ms_o (ms)
  );
  always_comb begin
    state_n = state;
    shrt_n  = 1'b0;
    dbl_n   = 1'b0;
    lng_n   = 1'b0;
    held_n  = bus.held;
    case (state)
      S_IDLE:   if (rise) state_n = S_PRESS1;
      S_PRESS1: if (fall) state_n = S_GAP;
                else if (at_long) begin
                  state_n = S_LONG;
                  lng_n   = 1'b1;
                  held_n  = 1'b1;
                end
      S_LONG:   if (fall) begin
                  state_n = S_IDLE;
                  held_n  = 1'b0;
                end
      S_GAP:    if (rise) state_n = S_PRESS2;
                else if (at_dbl) begin
                  state_n = S_IDLE;
                  shrt_n  = 1'b1;
                end
      S_PRESS2: if (fall) begin
                  state_n = S_IDLE;
                  dbl_n   = 1'b1;
                end else if (at_long) begin
                  state_n = S_LONG;
                  lng_n   = 1'b1;
                  held_n  = 1'b1;
                end
      default:  state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state            <= S_IDLE;
      sig_q            <= 1'b0;
      bus.press        <= 1'b0;
      bus.rel          <= 1'b0;
      bus.short_click  <= 1'b0;
      bus.double_click <= 1'b0;
      bus.long_press   <= 1'b0;
      bus.held         <= 1'b0;
    end else begin
      state            <= state_n;
      sig_q            <= bus.btn;
      bus.press        <= rise;
      bus.rel          <= fall;
      bus.short_click  <= shrt_n;
      bus.double_click <= dbl_n;
      bus.long_press   <= lng_n;
      bus.held         <= held_n;
    end
endmodule

// File: tb/tb_button_event.sv
// tb_button_event: directed plus random gestures checked against a duration-based model
module tb_button_event;
  localparam int c_clkfreq = 10000;
  localparam int c_longms  = 5;
  localparam int c_dblms   = 3;
  localparam int c_div     = c_clkfreq / 1000;
  // pulses are registered, so each threshold lands one clock after the nominal time
  localparam int c_l = c_longms * c_div + 1;
  localparam int c_d = c_dblms * c_div + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  button_event_if bus();
  button_event #(.c_clkfreq(c_clkfreq), .c_longms(c_longms), .c_dblms(c_dblms)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;

  logic [5:0] obs;
  assign obs = {bus.press, bus.rel, bus.short_click, bus.double_click, bus.long_press, bus.held};

  int tests = 0;
  int fails = 0;
  bit lvl[$];
  logic [5:0] exp_v[];
  int n;

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b (press rel short dbl long held)", tag, got, want);
    end
  endtask

  task automatic seg(input bit v, input int len);
    repeat (len) lvl.push_back(v);
  endtask

  function automatic int next_rise(input int from);
    for (int k = from; k < n; k++)
      if (lvl[k] && (k == 0 || !lvl[k-1])) return k;
    return -1;
  endfunction

  function automatic int next_fall(input int from);
    for (int k = from + 1; k < n; k++)
      if (!lvl[k]) return k;
    return n;
  endfunction

  task automatic mark_long(input int r, input int f);
    exp_v[r+c_l][1] = 1'b1;
    for (int e = r + c_l; e < f; e++) exp_v[e][0] = 1'b1;
  endtask

  initial begin
    int i, r, f, r2, f2;
    bit p;
    bus.btn = 1'b0;
    seg(0, 5);
    seg(1, 20); seg(0, 40);
    seg(1, 20); seg(0, 10); seg(1, 20); seg(0, 40);
    seg(1, 80); seg(0, 40);
    seg(1, c_l); seg(0, 40);
    seg(1, 20); seg(0, 10); seg(1, 60); seg(0, 40);
    seg(1, 20); seg(0, c_d); seg(1, 10); seg(0, 40);
    seg(1, 20); seg(0, c_d - 1); seg(1, 10); seg(0, 40);
    seg(1, 20); seg(0, c_d + 1); seg(1, 10); seg(0, 40);
    for (int k = 0; k < 40; k++) begin
      seg(1, $urandom_range(70, 1));
      seg(0, $urandom_range(45, 1));
    end
    seg(0, 60);
    n = lvl.size();
    exp_v = new[n];
    for (int k = 0; k < n; k++) begin
      p = k > 0 ? lvl[k-1] : 1'b0;
      exp_v[k] = {lvl[k] & ~p, ~lvl[k] & p, 4'b0};
    end
    i = 0;
    while (1) begin
      r = next_rise(i);
      if (r < 0) break;
      f = next_fall(r);
      if (f - r > c_l) begin
        mark_long(r, f);
        i = f;
      end else begin
        r2 = next_rise(f);
        if (r2 < 0 || r2 - f > c_d) begin
          exp_v[f+c_d][3] = 1'b1;
          i = f + 1;
        end else begin
          f2 = next_fall(r2);
          if (f2 - r2 > c_l) mark_long(r2, f2);
          else exp_v[f2][2] = 1'b1;
          i = f2;
        end
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("reset_state", obs, 6'b0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) bus.btn = lvl[k];
      @(posedge clk);
      #1 chk($sformatf("cycle%0d", k), obs, exp_v[k]);
    end

    @(negedge clk) bus.btn = 1'b1;
    repeat (20) @(negedge clk);
    bus.btn = 1'b0;
    @(posedge clk);
    #1 chk("release_before_rst", obs, 6'b010000);
    #2 rst = 1'b1;
    #1 chk("rst_clears_release", obs, 6'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 chk("no_short_after_rst", obs, 6'b0);
    end

    @(negedge clk) bus.btn = 1'b1;
    repeat (60) @(posedge clk);
    #1 chk("held_before_rst", obs, 6'b000001);
    #2 rst = 1'b1;
    #1 chk("rst_clears_held", obs, 6'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("press_after_rst", obs, 6'b100000);
    @(posedge clk);
    #1 chk("press_single_cycle", obs, 6'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
